// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// states, divide latency and small operand helpers.
package mdu_hilo_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // 32 radix-2 iterations plus one sign-fix/write cycle.
  localparam int unsigned DIV_CYCLES = 33;

  // Multi-cycle ops that hold the pipeline while they run.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Magnitude of a value that is negative when neg is set.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/mdu_hilo_div_radix2.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// Operands are captured on start; done pulses one cycle after the last
// iteration, while quotient/remainder hold the final values.
module div_radix2
  import mdu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q;
  logic        run_q;
  logic        fin_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Trial subtraction of the divisor from the partial remainder shifted
  // left by the next dividend bit.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Iteration sequencer: load on start, step while running, flag completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (cancel) begin
      run_q <= 1'b0;
      fin_q <= 1'b0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
      fin_q <= 1'b0;
    end else if (run_q) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'(DIV_CYCLES - 2)) begin
        run_q <= 1'b0;
        fin_q <= 1'b1;
      end
    end else begin
      fin_q <= 1'b0;
    end
  end

  assign done      = fin_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the architectural HI/LO registers. MULT/DIV
// run over several cycles and request a stall; MTHI/MTLO write in one cycle.
// An exception flush cancels any operation without touching HI/LO.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_q;
  logic [2:0]  cnt_q;
  logic [63:0] mul_a_q;
  logic [63:0] mul_b_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;
  logic [31:0] dz_a_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_signed_div;
  logic        a_neg;
  logic        b_neg;
  logic        accept;
  logic        div_start;
  logic        div_fin;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        mul_done;
  logic        done_raw;
  logic [63:0] product;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  // Issue decode and operand sign analysis for the divider.
  always_comb begin
    accept        = (state_q == ST_IDLE) && op_valid && !flush;
    is_signed_div = (op == MDU_DIV);
    a_neg         = is_signed_div && src_a[31];
    b_neg         = is_signed_div && src_b[31];
    div_start     = accept && ((op == MDU_DIV) || (op == MDU_DIVU));
  end

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (flush),
    .dividend  (mag32(src_a, a_neg)),
    .divisor   (mag32(src_b, b_neg)),
    .done      (div_fin),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result formation, completion pulse and stall request.
  always_comb begin
    product  = mul_a_q * mul_b_q;
    // Divide by zero bypasses the sign fix so signed and unsigned agree.
    if (dz_q) begin
      div_lo = '1;
      div_hi = dz_a_q;
    end else begin
      div_lo = q_neg_q ? (32'd0 - div_quo) : div_quo;
      div_hi = r_neg_q ? (32'd0 - div_rem) : div_rem;
    end
    mul_done = (state_q == ST_MUL) && (cnt_q == 3'(MUL_CYCLES - 1));
    done_raw = mul_done || ((state_q == ST_DIV) && div_fin);
    done     = done_raw && !flush;
    busy     = (accept && is_long_op(op)) ||
               ((state_q != ST_IDLE) && !done_raw && !flush);
  end

  // Control FSM plus HI/LO register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      dz_a_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                // Sign- or zero-extend so the low 64 product bits are exact.
                mul_a_q <= {{32{(op == MDU_MULT) && src_a[31]}}, src_a};
                mul_b_q <= {{32{(op == MDU_MULT) && src_b[31]}}, src_b};
                cnt_q   <= '0;
                state_q <= ST_MUL;
              end
              MDU_DIV, MDU_DIVU: begin
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                dz_q    <= (src_b == 32'd0);
                dz_a_q  <= src_a;
                cnt_q   <= '0;
                state_q <= ST_DIV;
              end
              MDU_MTHI: hi_q <= src_a;
              MDU_MTLO: lo_q <= src_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            hi_q    <= product[63:32];
            lo_q    <= product[31:0];
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DIV: begin
          if (div_fin) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes expected {hi,lo} for each
// MULT/DIV; a monitor pops on every done pulse and checks HI/LO next cycle.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned done_cnt = 0;
  logic [63:0] sb[$];

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  mdu_hilo #(.MUL_CYCLES(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expectation on done, compare HI/LO one cycle later.
  logic        pending = 1'b0;
  logic [63:0] exp_hl;
  initial begin
    forever begin
      @(negedge clk);
      if (pending) begin
        check("hi_after_done", hi, exp_hl[63:32]);
        check("lo_after_done", lo, exp_hl[31:0]);
        pending = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          exp_hl  = sb.pop_front();
          pending = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
  endtask

  // Walk cycles 0..lat of a long op checking busy/done each cycle.
  task automatic run_long(input int lat);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", k), {31'd0, busy}, {31'd0, (k < lat)});
      check($sformatf("done_c%0d", k), {31'd0, done}, {31'd0, (k == lat)});
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
  endtask

  task automatic issue_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input int lat);
    @(posedge clk); #1;
    drive(o, a, b);
    sb.push_back({eh, el});
    run_long(lat);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a, input logic fl);
    @(posedge clk); #1;
    drive(o, a, 32'd0);
    flush = fl;
    @(negedge clk);
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    int unsigned dc;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI
    mt(3'd4, 32'h1234_5678, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'd0);

    // Multiplies
    issue_long(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    issue_long(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
    issue_long(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);

    // Divides
    issue_long(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    issue_long(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    issue_long(3'd2, 32'd42, 32'd0, 32'd42, 32'hFFFF_FFFF, DIV_LAT);
    issue_long(3'd2, 32'hFFFF_FFD6, 32'd0, 32'hFFFF_FFD6, 32'hFFFF_FFFF, DIV_LAT);
    issue_long(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
    issue_long(3'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, DIV_LAT);

    // Preload, then MTLO with flush must not write
    mt(3'd4, 32'd1, 1'b0);
    mt(3'd5, 32'd2, 1'b0);
    mt(3'd5, 32'd99, 1'b1);
    check("mt_flush_lo", lo, 32'd2);
    check("mt_flush_hi", hi, 32'd1);

    // Undefined op is a no-op
    mt(3'd7, 32'hDEAD_BEEF, 1'b0);
    check("undef_hi", hi, 32'd1);
    check("undef_lo", lo, 32'd2);

    // DIVU flushed in cycle 10, MULT issued in cycle 11
    dc = done_cnt;
    @(posedge clk); #1;
    drive(3'd3, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("fl_div_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    check("fl_busy_c10", {31'd0, busy}, 32'd0);
    check("fl_done_c10", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_hi_kept", hi, 32'd1);
    check("fl_lo_kept", lo, 32'd2);
    check("fl_no_done", done_cnt, dc);
    drive(3'd0, 32'd6, 32'd7);
    sb.push_back({32'd0, 32'd42});
    run_long(MUL_LAT);

    // Flush in the MULT done cycle suppresses the write
    dc = done_cnt + 1;
    @(negedge clk);
    dc = done_cnt;
    @(posedge clk); #1;
    drive(3'd0, 32'd3, 32'd4);
    for (int k = 0; k < MUL_LAT; k++) begin
      @(negedge clk);
      check("mfl_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    check("mfl_done", {31'd0, done}, 32'd0);
    check("mfl_busy_flush", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("mfl_hi", hi, 32'd0);
    check("mfl_lo", lo, 32'd42);
    @(negedge clk);
    check("mfl_idle", {31'd0, busy}, 32'd0);
    check("mfl_no_done", done_cnt, dc);

    // Asynchronous reset mid-divide
    mt(3'd4, 32'h5555_AAAA, 1'b0);
    dc = done_cnt;
    @(posedge clk); #1;
    drive(3'd3, 32'd1000, 32'd3);
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, dc);
    check("arst_hi_hold", hi, 32'd0);
    check("arst_busy_idle", {31'd0, busy}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
